// File: rtl/framebuffer_arbiter_if.sv
// Signal bundle between the arbiter and its three neighbours: scan reader, host writer and pixel RAM.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface framebuffer_arbiter_if #(
  parameter int DATA_WIDTH = 36
);
  logic                  scan_rd_en;
  logic [3:0]            scan_row;
  logic [5:0]            scan_col;
  logic [DATA_WIDTH-1:0] scan_data;
  logic                  scan_data_valid;
  logic                  frame_start;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [3:0]            wr_row;
  logic [5:0]            wr_col;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  swap_req;
  logic                  swap_busy;
  logic                  swap_done;
  logic                  display_bank;
  logic [10:0]           ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  scan_rd_en, scan_row, scan_col, frame_start,
    input  wr_valid, wr_row, wr_col, wr_data, swap_req, ram_rdata,
    output scan_data, scan_data_valid, wr_ready, swap_busy, swap_done,
    output display_bank, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output scan_rd_en, scan_row, scan_col, frame_start,
    output wr_valid, wr_row, wr_col, wr_data, swap_req, ram_rdata,
    input  scan_data, scan_data_valid, wr_ready, swap_busy, swap_done,
    input  display_bank, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Single-port pixel RAM arbiter: scan reads win, host writes drain from a FIFO on idle cycles,
// and display/draw bank swaps wait for a frame boundary with an empty FIFO.
module framebuffer_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 36
) (
  input logic                  clk_in,
  input logic                  reset,
  framebuffer_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_WIDTH + 10;

  typedef enum logic {RUN, PENDING} state_e;

  state_e                 state_q, state_d;
  logic                   display_bank_q, display_bank_d;
  logic                   swap_done_q, swap_done_d;
  logic                   scan_data_valid_q, scan_data_valid_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]       mem_d [FIFO_DEPTH];
  logic [ENT_W-1:0]       head;
  logic                   wr_ready;
  logic                   push;
  logic                   pop;

  assign head     = mem_q[rd_ptr_q];
  assign wr_ready = !reset && (count_q < CNT_W'(FIFO_DEPTH)) && (state_q == RUN);
  assign push     = bus.wr_valid && wr_ready;
  assign pop      = !reset && !bus.scan_rd_en && (count_q != '0);

  assign bus.wr_ready        = wr_ready;
  assign bus.scan_data       = bus.ram_rdata;
  assign bus.scan_data_valid = scan_data_valid_q;
  assign bus.swap_busy       = (state_q == PENDING);
  assign bus.swap_done       = swap_done_q;
  assign bus.display_bank    = display_bank_q;

  // RAM port grant: scan first, then the FIFO head into the draw bank
  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    if (bus.scan_rd_en) begin
      bus.ram_addr = {display_bank_q, bus.scan_row, bus.scan_col};
    end else if (pop) begin
      bus.ram_we    = 1'b1;
      bus.ram_addr  = {~display_bank_q, head[ENT_W-1 -: 10]};
      bus.ram_wdata = head[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {bus.wr_row, bus.wr_col, bus.wr_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // The swap looks at the registered count, so a pop in the frame_start cycle does not qualify
  always_comb begin
    state_d           = state_q;
    display_bank_d    = display_bank_q;
    swap_done_d       = 1'b0;
    scan_data_valid_d = bus.scan_rd_en;
    case (state_q)
      RUN: begin
        if (bus.swap_req) state_d = PENDING;
      end
      PENDING: begin
        if (bus.frame_start && (count_q == '0)) begin
          display_bank_d = ~display_bank_q;
          swap_done_d    = 1'b1;
          state_d        = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q           <= RUN;
      display_bank_q    <= 1'b0;
      swap_done_q       <= 1'b0;
      scan_data_valid_q <= 1'b0;
      count_q           <= '0;
      rd_ptr_q          <= '0;
      wr_ptr_q          <= '0;
    end else begin
      state_q           <= state_d;
      display_bank_q    <= display_bank_d;
      swap_done_q       <= swap_done_d;
      scan_data_valid_q <= scan_data_valid_d;
      count_q           <= count_d;
      rd_ptr_q          <= rd_ptr_d;
      wr_ptr_q          <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Bench for framebuffer_arbiter: fixed vector table, hand sequences for swap/FIFO corners,
// and random traffic, all compared against a queue-based reference model.
module tb_framebuffer_arbiter;
  localparam int DW    = 36;
  localparam int DEPTH = 4;
  localparam int ENT   = DW + 10;

  typedef struct packed {
    logic          rst;
    logic          rd;
    logic [3:0]    srow;
    logic [5:0]    scol;
    logic          fs;
    logic          wv;
    logic [3:0]    wrow;
    logic [5:0]    wcol;
    logic [DW-1:0] wdata;
    logic          sq;
  } stim_t;

  typedef struct {
    stim_t         s;
    logic          we;
    logic          ca;
    logic [10:0]   addr;
    logic          ready;
    logic          vld;
    logic [DW-1:0] wd;
  } vec_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;

  framebuffer_arbiter_if #(.DATA_WIDTH(DW)) bus ();
  framebuffer_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [ENT-1:0] mq[$];
  logic m_bank = 1'b0, m_pend = 1'b0, m_done = 1'b0, m_valid = 1'b0;

  logic          o_we, o_ready, o_bank, o_busy, o_done, o_vld;
  logic [10:0]   o_addr;
  logic [DW-1:0] o_wd;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic stim_t S(bit rst, bit rd, logic [3:0] sr, logic [5:0] sc, bit fs, bit wv,
                              logic [3:0] wr, logic [5:0] wc, logic [DW-1:0] wd, bit sq);
    stim_t s;
    s.rst = rst; s.rd = rd; s.srow = sr; s.scol = sc; s.fs = fs;
    s.wv = wv; s.wrow = wr; s.wcol = wc; s.wdata = wd; s.sq = sq;
    return s;
  endfunction

  function automatic vec_t V(stim_t s, bit we, bit ca, logic [10:0] a, bit rdy, bit vld,
                             logic [DW-1:0] wd);
    vec_t v;
    v.s = s; v.we = we; v.ca = ca; v.addr = a; v.ready = rdy; v.vld = vld; v.wd = wd;
    return v;
  endfunction

  // One clock: drive at posedge+1, compare at the falling edge, advance the model at posedge
  task automatic cyc(input stim_t s);
    logic [63:0]    r;
    logic [ENT-1:0] hd;
    logic           e_ready, e_we;
    logic [10:0]    e_addr;
    int             sz;
    r = {$urandom, $urandom};
    reset            = s.rst;
    bus.scan_rd_en   = s.rd;
    bus.scan_row     = s.srow;
    bus.scan_col     = s.scol;
    bus.frame_start  = s.fs;
    bus.wr_valid     = s.wv;
    bus.wr_row       = s.wrow;
    bus.wr_col       = s.wcol;
    bus.wr_data      = s.wdata;
    bus.swap_req     = s.sq;
    bus.ram_rdata    = r[DW-1:0];
    sz = mq.size();
    hd = '0;
    if (sz > 0) hd = mq[0];
    e_ready = !s.rst && (sz < DEPTH) && !m_pend;
    e_we    = !s.rst && !s.rd && (sz > 0);
    if (s.rd)      e_addr = {m_bank, s.srow, s.scol};
    else if (e_we) e_addr = {~m_bank, hd[ENT-1 -: 10]};
    else           e_addr = '0;
    #4;
    o_we = bus.ram_we; o_ready = bus.wr_ready; o_bank = bus.display_bank;
    o_busy = bus.swap_busy; o_done = bus.swap_done; o_vld = bus.scan_data_valid;
    o_addr = bus.ram_addr; o_wd = bus.ram_wdata;
    if (chk_en) begin
      chk("wr_ready", o_ready, e_ready);
      chk("ram_we", o_we, e_we);
      if (!s.rst) chk("ram_addr", o_addr, e_addr);
      if (e_we) chk("ram_wdata", o_wd, hd[DW-1:0]);
      chk("display_bank", o_bank, m_bank);
      chk("swap_busy", o_busy, m_pend);
      chk("swap_done", o_done, m_done);
      chk("scan_data_valid", o_vld, m_valid);
      if (m_valid) chk("scan_data", bus.scan_data, r[DW-1:0]);
    end
    @(posedge clk_in);
    if (s.rst) begin
      mq.delete();
      m_bank = 1'b0; m_pend = 1'b0; m_done = 1'b0; m_valid = 1'b0;
    end else begin
      m_valid = s.rd;
      m_done  = 1'b0;
      if (m_pend) begin
        if (s.fs && sz == 0) begin
          m_bank = ~m_bank; m_pend = 1'b0; m_done = 1'b1;
        end
      end else if (s.sq) begin
        m_pend = 1'b1;
      end
      if (e_we) void'(mq.pop_front());
      if (s.wv && e_ready) mq.push_back({s.wrow, s.wcol, s.wdata});
    end
    #1;
  endtask

  initial begin
    stim_t idle, s;
    logic [DW-1:0] d[4];
    idle = '0;
    bus.scan_rd_en = 1'b0; bus.scan_row = '0; bus.scan_col = '0; bus.frame_start = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0;
    bus.swap_req = 1'b0; bus.ram_rdata = '0;

    tbl[0] = V(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 11'h000, 0, 0, '0);
    tbl[1] = V(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 11'h000, 0, 0, '0);
    tbl[2] = V(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 11'h000, 1, 0, '0);
    tbl[3] = V(S(0, 1, 3, 10, 0, 0, 0, 0, 0, 0), 0, 1, 11'h0CA, 1, 0, '0);
    tbl[4] = V(S(0, 0, 0, 0, 0, 1, 1, 2, 36'hABC, 0), 0, 1, 11'h000, 1, 1, '0);
    tbl[5] = V(S(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 11'h000, 1, 0, '0);
    tbl[6] = V(S(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 11'h000, 1, 1, '0);
    tbl[7] = V(S(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 11'h000, 1, 1, '0);
    tbl[8] = V(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 11'h442, 1, 1, 36'hABC);
    tbl[9] = V(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 11'h000, 1, 0, '0);

    @(posedge clk_in);
    #1;
    cyc(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].s);
      chk($sformatf("tbl%0d_we", i), o_we, tbl[i].we);
      chk($sformatf("tbl%0d_ready", i), o_ready, tbl[i].ready);
      chk($sformatf("tbl%0d_valid", i), o_vld, tbl[i].vld);
      chk($sformatf("tbl%0d_bank", i), o_bank, 1'b0);
      if (tbl[i].ca) chk($sformatf("tbl%0d_addr", i), o_addr, tbl[i].addr);
      if (tbl[i].we) chk($sformatf("tbl%0d_wdata", i), o_wd, tbl[i].wd);
    end

    // FIFO full under sustained scan, then in-order drain
    for (int i = 0; i < 4; i++) begin
      d[i] = DW'(36'h100 + i * 36'h11);
      cyc(S(0, 1, 4'(i), 6'(i), 0, 1, 4'(i + 4), 6'(i + 8), d[i], 0));
    end
    cyc(S(0, 1, 0, 0, 0, 1, 4'hF, 6'h3F, 36'hDEAD, 0));
    chk("full_ready", o_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(idle);
      chk($sformatf("drain%0d_we", i), o_we, 1'b1);
      chk($sformatf("drain%0d_wdata", i), o_wd, d[i]);
      chk($sformatf("drain%0d_ready", i), o_ready, (i == 0) ? 1'b0 : 1'b1);
    end

    // Swap request with two writes queued: first frame_start must not toggle
    cyc(S(0, 1, 0, 0, 0, 1, 2, 3, 36'h111, 0));
    cyc(S(0, 1, 0, 0, 0, 1, 2, 4, 36'h222, 0));
    cyc(S(0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc(S(0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    chk("pend_busy", o_busy, 1'b1);
    chk("pend_ready", o_ready, 1'b0);
    cyc(S(0, 0, 0, 0, 0, 1, 5, 5, 36'h333, 0));
    chk("pend_no_toggle", o_bank, 1'b0);
    chk("pend_drain_we", o_we, 1'b1);
    cyc(idle);
    chk("pend_ready2", o_ready, 1'b0);
    cyc(idle);
    s = idle; s.fs = 1'b1;
    cyc(s);
    cyc(idle);
    chk("swap_bank", o_bank, 1'b1);
    chk("swap_done_pulse", o_done, 1'b1);
    chk("swap_busy_clear", o_busy, 1'b0);
    cyc(idle);
    chk("swap_done_once", o_done, 1'b0);

    // swap_req coinciding with frame_start in RUN only arms the swap
    cyc(S(0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    cyc(idle);
    chk("coincide_busy", o_busy, 1'b1);
    chk("coincide_bank", o_bank, 1'b1);
    cyc(s);
    cyc(idle);
    chk("coincide_swap", o_bank, 1'b0);

    // Swap bank to 1, then reset in PENDING with three writes queued
    cyc(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc(s);
    for (int i = 0; i < 3; i++) cyc(S(0, 1, 0, 0, 0, 1, 4'(i), 6'(i), 36'h5A5, 0));
    cyc(S(0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    cyc(S(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("midswap_busy", o_busy, 1'b1);
    chk("midswap_bank", o_bank, 1'b1);
    cyc(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("midswap_rst_we", o_we, 1'b0);
    cyc(idle);
    chk("midswap_bank0", o_bank, 1'b0);
    chk("midswap_idle", o_busy, 1'b0);
    chk("midswap_no_we", o_we, 1'b0);
    chk("midswap_ready", o_ready, 1'b1);

    for (int i = 0; i < 800; i++) begin
      s.rst   = ($urandom_range(0, 99) == 0);
      s.rd    = ($urandom_range(0, 99) < 55);
      s.srow  = 4'($urandom);
      s.scol  = 6'($urandom);
      s.fs    = ($urandom_range(0, 9) == 0);
      s.wv    = ($urandom_range(0, 1) == 1);
      s.wrow  = 4'($urandom);
      s.wcol  = 6'($urandom);
      s.wdata = DW'({$urandom, $urandom});
      s.sq    = ($urandom_range(0, 19) == 0);
      cyc(s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
